// File: rtl/shift_deser_pkg.sv
// Shared types and constants for the shift deserializer: FSM state encoding,
// entry-direction codes and the default word length.
package shift_deser_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FULL    = 2'd2
    } deser_state_t;

    localparam logic DIR_RIGHT     = 1'b0;
    localparam logic DIR_LEFT      = 1'b1;
    localparam int   DEFAULT_WIDTH = 4;

endpackage

// File: rtl/shift_deser_ctrl.sv
// Control half of the shift deserializer: FSM, bit counter, input handshake
// and output-slot arbitration. The datapath in the top only follows the
// strobes produced here.
module shift_deser_ctrl
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         ser_valid,
    input  logic                         flush,
    input  logic                         word_valid,
    input  logic                         word_ready,
    output logic                         ser_ready,
    output logic                         accept,
    output logic                         first_bit,
    output logic                         emit_new,
    output logic                         emit_held,
    output logic                         flush_asm,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    localparam int               CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);

    deser_state_t     state;
    deser_state_t     next_state;
    logic [CNT_W-1:0] cnt_next;
    logic             slot_free;
    logic             last_bit;

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            state   <= next_state;
            bit_cnt <= cnt_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = bit_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = COLLECT;
                    cnt_next   = CNT_W'(1);
                end
            end
            COLLECT: begin
                if (flush) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end else if (accept) begin
                    if (bit_cnt == LAST_CNT) begin
                        // A completed word either goes straight out or parks here until the slot frees.
                        next_state = slot_free ? IDLE : FULL;
                        cnt_next   = slot_free ? '0 : FULL_CNT;
                    end else begin
                        cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            FULL: begin
                if (slot_free) begin
                    next_state = IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        slot_free = !word_valid || word_ready;
        ser_ready = (state != FULL);
        // A bit offered alongside flush is dropped rather than seeding the next word.
        accept    = ser_valid && ser_ready && !flush;
        first_bit = accept && (bit_cnt == '0);
        last_bit  = accept && (bit_cnt == LAST_CNT);
        emit_new  = last_bit && slot_free;
        emit_held = (state == FULL) && slot_free;
        flush_asm = flush && (state != FULL);
    end

endmodule

// File: rtl/shift_deserializer.sv
// Serial-to-parallel converter with selectable entry direction and a
// one-word output slot using a valid/ready handshake on both sides.
module shift_deserializer
    import shift_deser_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                         clk,
    input  logic                         clear,
    input  logic                         ser_in,
    input  logic                         ser_valid,
    output logic                         ser_ready,
    input  logic                         dir,
    input  logic                         flush,
    output logic [WIDTH-1:0]             word_out,
    output logic                         word_valid,
    input  logic                         word_ready,
    output logic [$clog2(WIDTH+1)-1:0]   bit_cnt
);

    logic [WIDTH-1:0] asm_reg;
    logic [WIDTH-1:0] shifted;
    logic             dir_hold;
    logic             dir_eff;
    logic             accept;
    logic             first_bit;
    logic             emit_new;
    logic             emit_held;
    logic             flush_asm;

    shift_deser_ctrl #(
        .WIDTH (WIDTH)
    ) u_ctrl (
        .clk        (clk),
        .clear      (clear),
        .ser_valid  (ser_valid),
        .flush      (flush),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .ser_ready  (ser_ready),
        .accept     (accept),
        .first_bit  (first_bit),
        .emit_new   (emit_new),
        .emit_held  (emit_held),
        .flush_asm  (flush_asm),
        .bit_cnt    (bit_cnt)
    );

    // Direction is latched by the first bit of a word so mid-word toggles are ignored.
    always_comb begin
        dir_eff = first_bit ? dir : dir_hold;
        shifted = (dir_eff == DIR_LEFT) ? {asm_reg[WIDTH-2:0], ser_in}
                                        : {ser_in, asm_reg[WIDTH-1:1]};
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            asm_reg  <= '0;
            dir_hold <= DIR_RIGHT;
        end else if (flush_asm) begin
            asm_reg  <= '0;
        end else if (accept) begin
            asm_reg  <= shifted;
            dir_hold <= dir_eff;
        end
    end

    // The final bit is forwarded straight from the shifter so a free slot costs no extra cycle.
    always_ff @(posedge clk) begin
        if (clear) begin
            word_out   <= '0;
            word_valid <= 1'b0;
        end else if (emit_new) begin
            word_out   <= shifted;
            word_valid <= 1'b1;
        end else if (emit_held) begin
            word_out   <= asm_reg;
            word_valid <= 1'b1;
        end else if (word_valid && word_ready) begin
            word_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer (WIDTH=4): directed scenarios followed by
// random traffic, all compared against a queue-based word model.
module tb_shift_deserializer;

    localparam int WIDTH = 4;
    localparam int CNT_W = $clog2(WIDTH + 1);

    logic             clk = 1'b0;
    logic             clear = 1'b0;
    logic             ser_in = 1'b0;
    logic             ser_valid = 1'b0;
    logic             ser_ready;
    logic             dir = 1'b0;
    logic             flush = 1'b0;
    logic [WIDTH-1:0] word_out;
    logic             word_valid;
    logic             word_ready = 1'b0;
    logic [CNT_W-1:0] bit_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: bits of the word in arrival order, plus the output slot.
    bit               m_bits[$];
    bit               m_dir;
    bit               m_full;
    logic [WIDTH-1:0] m_held;
    logic [WIDTH-1:0] m_out;
    bit               m_valid;

    shift_deserializer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .clear      (clear),
        .ser_in     (ser_in),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .dir        (dir),
        .flush      (flush),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .bit_cnt    (bit_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] assembleWord(input bit left);
        logic [WIDTH-1:0] w;
        w = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (left) w[WIDTH-1-i] = m_bits[i];
            else      w[i]         = m_bits[i];
        end
        return w;
    endfunction

    task automatic modelEdge();
        bit slot_free;
        bit emitted;
        slot_free = !m_valid || word_ready;
        emitted   = 1'b0;
        if (clear) begin
            m_bits.delete();
            m_full  = 1'b0;
            m_held  = '0;
            m_out   = '0;
            m_valid = 1'b0;
        end else if (m_full) begin
            if (slot_free) begin
                m_out   = m_held;
                m_valid = 1'b1;
                m_full  = 1'b0;
                m_bits.delete();
            end
        end else begin
            if (flush) begin
                m_bits.delete();
            end else if (ser_valid) begin
                if (m_bits.size() == 0) m_dir = dir;
                m_bits.push_back(ser_in);
                if (m_bits.size() == WIDTH) begin
                    if (slot_free) begin
                        m_out   = assembleWord(m_dir);
                        m_valid = 1'b1;
                        emitted = 1'b1;
                        m_bits.delete();
                    end else begin
                        m_held = assembleWord(m_dir);
                        m_full = 1'b1;
                    end
                end
            end
            if (!emitted && m_valid && word_ready) m_valid = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic c, input logic f, input logic v,
                                 input logic b, input logic d, input logic r);
        clear      = c;
        flush      = f;
        ser_valid  = v;
        ser_in     = b;
        dir        = d;
        word_ready = r;
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [CNT_W-1:0] exp_cnt;
        exp_cnt = m_full ? CNT_W'(WIDTH) : CNT_W'(m_bits.size());
        checkValue({tag, ".word_valid"}, 32'(word_valid), 32'(m_valid));
        if (m_valid) checkValue({tag, ".word_out"}, 32'(word_out), 32'(m_out));
        checkValue({tag, ".ser_ready"}, 32'(ser_ready), 32'(!m_full));
        checkValue({tag, ".bit_cnt"}, 32'(bit_cnt), 32'(exp_cnt));
    endtask

    task automatic sendBits(input string tag, input logic [3:0] bits, input logic d, input logic r);
        for (int i = 3; i >= 0; i--) begin
            applyStimulus(1'b0, 1'b0, 1'b1, bits[i], d, r);
            checkOutput(tag);
        end
    endtask

    initial begin
        m_dir   = 1'b0;
        m_full  = 1'b0;
        m_held  = '0;
        m_out   = '0;
        m_valid = 1'b0;

        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset");
        checkValue("reset.word_out", 32'(word_out), 32'h0);
        checkValue("reset.ser_ready", 32'(ser_ready), 32'h1);

        // Left entry, first bit lands in the MSB.
        sendBits("left", 4'b1010, 1'b1, 1'b1);
        checkValue("left.word", 32'(word_out), 32'hA);
        checkValue("left.valid", 32'(word_valid), 32'h1);

        // Right entry with dir toggled after the first bit.
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("right0");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("right1");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("right2");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("right3");
        checkValue("right.word", 32'(word_out), 32'h5);

        // Backpressure: second word parks in FULL until the slot frees.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("drain");
        sendBits("bp.first", 4'b1010, 1'b1, 1'b0);
        sendBits("bp.second", 4'b0110, 1'b1, 1'b0);
        checkValue("bp.held_out", 32'(word_out), 32'hA);
        checkValue("bp.ser_ready", 32'(ser_ready), 32'h0);
        checkValue("bp.bit_cnt", 32'(bit_cnt), 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("bp.flush_in_full");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("bp.release");
        checkValue("bp.new_out", 32'(word_out), 32'h6);
        checkValue("bp.new_valid", 32'(word_valid), 32'h1);
        checkValue("bp.ready_after", 32'(ser_ready), 32'h1);

        // Flush mid-word, with a bit offered on the flush cycle.
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("fl.drain");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("fl.b0");
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("fl.b1");
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("fl.flush");
        checkValue("fl.cnt", 32'(bit_cnt), 32'h0);
        sendBits("fl.word", 4'b0011, 1'b1, 1'b1);
        checkValue("fl.result", 32'(word_out), 32'h3);

        // Clear while FULL with a word pending, plus competing inputs.
        sendBits("cl.first", 4'b1100, 1'b1, 1'b0);
        sendBits("cl.second", 4'b0101, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        checkOutput("cl.after");
        checkValue("cl.word_out", 32'(word_out), 32'h0);
        checkValue("cl.word_valid", 32'(word_valid), 32'h0);
        checkValue("cl.bit_cnt", 32'(bit_cnt), 32'h0);
        checkValue("cl.ser_ready", 32'(ser_ready), 32'h1);

        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 49) == 0),
                          ($urandom_range(0, 11) == 0),
                          ($urandom_range(0, 9) < 7),
                          1'($urandom),
                          1'($urandom),
                          ($urandom_range(0, 1) == 1));
            checkOutput("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
